// File: rtl/mv_dac_i2s_tx_pkg.sv
// Shared constants, capture-state type and the 13-bit saturation rule for the DAC I2S transmitter.
package mv_dac_i2s_tx_pkg;

  localparam int unsigned FrameLen = 256;
  localparam int unsigned BclkDiv  = 4;
  localparam int unsigned SampleW  = 16;
  localparam int unsigned SlotW    = 32;
  localparam int unsigned StepW    = $clog2(FrameLen);
  localparam int unsigned PhaseW   = $clog2(BclkDiv);

  localparam logic [SampleW-1:0] SatPos   = 16'h0FFF;
  localparam logic [SampleW-1:0] SatNeg   = 16'hF000;
  localparam int unsigned        SatShift = 3;

  typedef enum logic [1:0] {CapR, CapL, CapDone} cap_e;

  // Clamp to 13-bit range, then align to the top of the 16-bit I2S word.
  function automatic logic [SampleW-1:0] saturate(input logic [SampleW-1:0] d);
    logic [SampleW-1:0] v;
    if (d[15:12] == 4'h0 || d[15:12] == 4'hF) begin
      v = d;
    end else begin
      v = d[15] ? SatNeg : SatPos;
    end
    return v << SatShift;
  endfunction

endpackage

// File: rtl/mv_dac_i2s_tx_if.sv
// DSP-side DAC output bus: frame marker, load strobe and output word.
interface mv_dac_i2s_tx_if;
  import mv_dac_i2s_tx_pkg::*;

  logic               frame_sync;
  logic               ld_dac;
  logic [SampleW-1:0] dac_d;

  modport master (output frame_sync, ld_dac, dac_d);
  modport slave  (input  frame_sync, ld_dac, dac_d);

endinterface

// File: rtl/mv_dac_i2s_tx_shift.sv
// One 32-bit I2S slot shifter; bit_o is the bit that will be on the line after this clock edge.
module mv_dac_i2s_tx_shift
  import mv_dac_i2s_tx_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               shift_en_i,
  input  logic [SampleW-1:0] word_i,
  output logic               bit_o
);

  logic [SlotW-1:0] shreg_q, shreg_d;

  // Leading zero gives the standard one-slot I2S delay before the MSB.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = {1'b0, word_i, {(SlotW-SampleW-1){1'b0}}};
    end else if (shift_en_i) begin
      shreg_d = {shreg_q[SlotW-2:0], 1'b0};
    end
  end

  assign bit_o = shreg_d[SlotW-1];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/mv_dac_i2s_tx.sv
// Captures the DSP's right/left DAC words each frame, saturates them and serialises them as I2S.
module mv_dac_i2s_tx
  import mv_dac_i2s_tx_pkg::*;
(
  input  logic           clk_i,
  input  logic           reset_i,
  mv_dac_i2s_tx_if.slave dac_if,
  output logic           i2s_bclk_o,
  output logic           i2s_lrck_o,
  output logic           i2s_sdata_o,
  output logic           ovr_err_o,
  output logic           sync_err_o
);

  localparam logic [StepW-1:0] LastStep = StepW'(FrameLen - 1);

  logic [StepW-1:0]   step_q, step_d;
  cap_e               cap_q, cap_d, cap_cur;
  logic [SampleW-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d, sat_word;
  logic               bclk_q, bclk_d, lrck_q, lrck_d, sdata_q, sdata_d;
  logic               ovr_q, ovr_d, sync_q, sync_d;
  logic               wrap, phase0, right_half, shift_l_en, shift_r_en, bit_l, bit_r;

  // Outputs are computed from step_d so the registered values line up with step_q.
  always_comb begin
    step_d     = dac_if.frame_sync ? '0 : step_q + StepW'(1);
    wrap       = (step_d == '0);
    phase0     = (step_d[PhaseW-1:0] == '0);
    right_half = step_d[StepW-1];
    shift_l_en = phase0 && !right_half;
    shift_r_en = phase0 && right_half && (step_d[StepW-2:PhaseW] != '0);
    sat_word   = saturate(dac_if.dac_d);
  end

  always_comb begin
    cap_cur  = dac_if.frame_sync ? CapR : cap_q;
    cap_d    = cap_cur;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    ovr_d    = ovr_q;
    if (dac_if.ld_dac) begin
      unique case (cap_cur)
        CapR: begin
          hold_r_d = sat_word;
          cap_d    = CapL;
        end
        CapL: begin
          hold_l_d = sat_word;
          cap_d    = CapDone;
        end
        default: ovr_d = 1'b1;
      endcase
    end
    sync_d  = sync_q | (dac_if.frame_sync && (step_q != LastStep));
    bclk_d  = step_d[PhaseW-1];
    lrck_d  = phase0 ? right_half : lrck_q;
    sdata_d = phase0 ? (right_half ? bit_r : bit_l) : sdata_q;
  end

  mv_dac_i2s_tx_shift u_shift_l (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (wrap),
    .shift_en_i (shift_l_en),
    .word_i     (hold_l_q),
    .bit_o      (bit_l)
  );

  mv_dac_i2s_tx_shift u_shift_r (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (wrap),
    .shift_en_i (shift_r_en),
    .word_i     (hold_r_q),
    .bit_o      (bit_r)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      step_q   <= '0;
      cap_q    <= CapR;
      hold_l_q <= '0;
      hold_r_q <= '0;
      bclk_q   <= 1'b0;
      lrck_q   <= 1'b0;
      sdata_q  <= 1'b0;
      ovr_q    <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      step_q   <= step_d;
      cap_q    <= cap_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      bclk_q   <= bclk_d;
      lrck_q   <= lrck_d;
      sdata_q  <= sdata_d;
      ovr_q    <= ovr_d;
      sync_q   <= sync_d;
    end
  end

  assign i2s_bclk_o  = bclk_q;
  assign i2s_lrck_o  = lrck_q;
  assign i2s_sdata_o = sdata_q;
  assign ovr_err_o   = ovr_q;
  assign sync_err_o  = sync_q;

endmodule
